slot_entry_tracker: RTL
=======================

# slot_entry_tracker

Upstream stage of the parking cost calculator. It owns the parking time base and a table of per-slot entry timestamps. It allocates a slot when a car enters and frees it when the car leaves. On each exit it presents the recorded `Entry_time` together with `current_time`, so the downstream `ccost` stage can compute the charge. An `Entry_time` of 0 means "no car" throughout the design, so this block never records 0 as an entry time.

## Interface
Parameters:
- `NUM_SLOTS`, default 8: number of parking slots, 2..32.
- `TICK_DIV`, default 100: clk cycles per time unit, at least 1.
- `OVERSTAY_LIMIT`, default 200: elapsed time units that raise the overstay flag. Used only when `PARK_OVERSTAY_EN` is defined.

Ports (`SW` = clog2(`NUM_SLOTS`)):
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `car_in` input 1: one-cycle entry request.
- `car_out` input 1: one-cycle exit request.
- `out_slot` input `SW`: slot being exited; sampled when `car_out` = 1.
- `current_time` output 8: time-base counter, wraps 255→0.
- `Entry_time` output 8: entry time of the last valid exit; 0 when there is none.
- `entry_ack` output 1: one-cycle pulse; entry accepted.
- `entry_reject` output 1: one-cycle pulse; lot full.
- `slot_id` output `SW`: slot allocated to the last accepted entry.
- `exit_err` output 1: one-cycle pulse; `car_out` named a free slot.
- `full` output 1: all slots occupied.
- `empty` output 1: no slots occupied.
- `overstay` output `NUM_SLOTS`: per-slot overstay flags. Present only with `PARK_OVERSTAY_EN`.

## Operation
- Time base:
  - A prescaler counts 0..`TICK_DIV`-1.
  - At terminal count it wraps and `current_time` increments modulo 256.
- Slot table: one occupied bit plus an 8-bit stamp per slot.
- Entry, when `car_in` = 1:
  - If not full: allocate the lowest-index free slot.
  - Stamp = `current_time`, except a `current_time` of 0 is stored as 1.
  - Set the occupied bit, drive `slot_id`, pulse `entry_ack`.
  - If full: pulse `entry_reject`; no state change.
- Exit, when `car_out` = 1:
  - If `out_slot` is occupied: `Entry_time` ← stamp, clear the occupied bit and stamp.
  - If free or out of range: pulse `exit_err`, `Entry_time` ← 0.
- `Entry_time` holds its value until the next `car_out`.
- Simultaneous `car_in` and `car_out`:
  - Both are processed in the same cycle.
  - Allocation uses occupancy from before the exit, so a full lot rejects the entry even if a car leaves that cycle.
  - The slot freed that cycle is not reused until the next cycle.
- `full` and `empty` are registered and reflect the table after the current cycle's updates.
- Reset values:
  - `current_time`, prescaler, `Entry_time`, `slot_id` = 0.
  - All pulse outputs = 0.
  - Table cleared; `empty` = 1, `full` = 0.
  - `overstay` = 0.
- Reset mid-operation: all parked records are lost. Reset is asynchronous, so a request in flight produces no ack.

## Timing
- All outputs are registered.
- `entry_ack`/`entry_reject`/`slot_id` are valid one cycle after `car_in`.
- `Entry_time`/`exit_err` are valid one cycle after `car_out`.
- The downstream `ccost` registers its result one cycle later, so request-to-cost latency is 2 cycles.
- Back-to-back requests on consecutive cycles are supported; there is no busy state.
- `current_time` advances exactly once every `TICK_DIV` cycles. With `TICK_DIV` = 1 it advances every cycle.

## Configuration
- Macro `PARK_OVERSTAY_EN`.
- When defined, for each occupied slot, every cycle:
  - Compute elapsed = (`current_time` − stamp) mod 256.
  - `overstay[i]` = 1 when elapsed ≥ `OVERSTAY_LIMIT`.
  - The flag clears when the slot is exited.
- When not defined: no `overstay` port, no comparators. All other behaviour is identical.

## Structure
- Shared package `park_pkg`:
  - `TIME_W` = 8.
  - A `park_time_t` typedef.
  - `NO_CAR_TIME` = 0.
  - `MIN_STAMP` = 1.
  - These are reused by `ccost` and billing.
- Sub-module `park_time_base`: prescaler plus 8-bit wrapping counter, outputs `current_time`. The slot table, priority allocator and exit logic stay in the top module.

## Test plan
- Reset, then 3 × `car_in` with `TICK_DIV` = 1 → `entry_ack` each time, `slot_id` = 0, 1, 2; `empty` falls after the first entry.
- Enter at `current_time` = 10, exit that slot at `current_time` = 50 → `Entry_time` = 10 one cycle after `car_out`; downstream cost = 40.
- Fill all 8 slots, then `car_in` together with `car_out` for slot 3 → `entry_reject`, slot 3 freed; the next `car_in` gets `slot_id` = 3.
- `car_out` on a free slot 5 → `exit_err` pulse, `Entry_time` = 0, table unchanged.
- Entry at `current_time` = 0 → stamp 1. Entry at 250, exit after the wrap at 4 → `Entry_time` = 250; downstream cost = 10.
- With `PARK_OVERSTAY_EN`, `OVERSTAY_LIMIT` = 20: enter at 5; at 24 `overstay[0]` = 0, at 25 it is 1; it clears on exit. Assert `reset` mid-stay → all outputs return to reset values.

Source files
------------

// File: rtl/park_pkg.sv
// Shared parking types: time width, time type and the reserved "no car" stamp.
// Reused by slot_entry_tracker, ccost and billing.
package park_pkg;

    localparam int TIME_W = 8;

    typedef logic [TIME_W-1:0] park_time_t;

    localparam park_time_t NO_CAR_TIME = '0;
    localparam park_time_t MIN_STAMP   = park_time_t'(1);

    // Time 0 is reserved for "no car", so an entry at 0 is recorded as 1.
    function automatic park_time_t to_stamp(input park_time_t t);
        return (t == NO_CAR_TIME) ? MIN_STAMP : t;
    endfunction

endpackage

// File: rtl/park_time_base.sv
// Parking time base: prescaler of TICK_DIV cycles driving an 8-bit wrapping
// time counter. tick_o flags the cycle in which the counter advances.
module park_time_base
    import park_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tick_o,
    output park_time_t current_time_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    park_time_t    time_q, time_d;

    assign tick_o         = (presc_q == TC);
    assign current_time_o = time_q;

    always_comb begin
        presc_d = tick_o ? '0 : presc_q + PW'(1);
        time_d  = tick_o ? time_q + park_time_t'(1) : time_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            time_q  <= '0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

endmodule

// File: rtl/slot_entry_tracker.sv
// Parking slot table: allocates slots on entry, returns entry stamps on exit.
// Optional per-slot overstay flags are built when PARK_OVERSTAY_EN is defined.
module slot_entry_tracker
    import park_pkg::*;
#(
    parameter  int NUM_SLOTS      = 8,
    parameter  int TICK_DIV       = 100,
    parameter  int OVERSTAY_LIMIT = 200,
    localparam int SW             = $clog2(NUM_SLOTS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          car_in,
    input  logic          car_out,
    input  logic [SW-1:0] out_slot,
    output logic [7:0]    current_time,
    output logic [7:0]    Entry_time,
    output logic          entry_ack,
    output logic          entry_reject,
    output logic [SW-1:0] slot_id,
    output logic          exit_err,
    output logic          full,
    output logic          empty
`ifdef PARK_OVERSTAY_EN
   ,output logic [NUM_SLOTS-1:0] overstay
`endif
);

    localparam logic [SW:0] NS = (SW + 1)'(NUM_SLOTS);

    logic       tick;
    park_time_t cur_time;

    park_time_base #(.TICK_DIV(TICK_DIV)) u_time_base (
        .clk           (clk),
        .reset         (reset),
        .tick_o        (tick),
        .current_time_o(cur_time)
    );

    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    park_time_t           stamp_q [NUM_SLOTS];
    park_time_t           stamp_d [NUM_SLOTS];
    park_time_t           etime_q, etime_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 ack_q, ack_d, rej_q, rej_d, err_q, err_d;
    logic                 full_q, full_d, empty_q, empty_d;

    logic          has_free;
    logic [SW-1:0] free_idx;
    logic          out_ok, exit_hit;

    // Priority pick works on pre-exit occupancy, so a slot freed this
    // cycle only becomes allocatable next cycle.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                has_free = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    assign out_ok   = ({1'b0, out_slot} < NS);
    assign exit_hit = car_out && out_ok && occ_q[out_slot];

    always_comb begin
        occ_d   = occ_q;
        stamp_d = stamp_q;
        etime_d = etime_q;
        slot_d  = slot_q;
        ack_d   = 1'b0;
        rej_d   = 1'b0;
        err_d   = 1'b0;
        if (car_out) begin
            if (exit_hit) begin
                etime_d           = stamp_q[out_slot];
                occ_d[out_slot]   = 1'b0;
                stamp_d[out_slot] = NO_CAR_TIME;
            end else begin
                err_d   = 1'b1;
                etime_d = NO_CAR_TIME;
            end
        end
        if (car_in) begin
            if (has_free) begin
                occ_d[free_idx]   = 1'b1;
                stamp_d[free_idx] = to_stamp(cur_time);
                slot_d            = free_idx;
                ack_d             = 1'b1;
            end else begin
                rej_d = 1'b1;
            end
        end
        full_d  = &occ_d;
        empty_d = ~|occ_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q   <= '0;
            etime_q <= NO_CAR_TIME;
            slot_q  <= '0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) stamp_q[i] <= NO_CAR_TIME;
        end else begin
            occ_q   <= occ_d;
            stamp_q <= stamp_d;
            etime_q <= etime_d;
            slot_q  <= slot_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign current_time = cur_time;
    assign Entry_time   = etime_q;
    assign entry_ack    = ack_q;
    assign entry_reject = rej_q;
    assign slot_id      = slot_q;
    assign exit_err     = err_q;
    assign full         = full_q;
    assign empty        = empty_q;

`ifdef PARK_OVERSTAY_EN
    park_time_t           time_nx;
    logic [NUM_SLOTS-1:0] ovr_q, ovr_d;

    // Evaluated against post-update time and table so the flag lines up
    // with the current_time value presented alongside it.
    always_comb begin
        time_nx = tick ? cur_time + park_time_t'(1) : cur_time;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ovr_d[i] = occ_d[i] &&
                (int'(park_time_t'(time_nx - stamp_d[i])) >= OVERSTAY_LIMIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_q <= '0;
        else       ovr_q <= ovr_d;
    end

    assign overstay = ovr_q;
`else
    logic unused_tick;
    assign unused_tick = tick;
`endif

endmodule
